// File: rtl/loader_pkg.sv
// Shared types and constants for the UART boot loader: loader FSM states,
// receiver states and the sync byte that opens every image.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_WORD_HI,
        ST_WORD_LO,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver driven by an oversample clock enable; emits one-clk
// strobes for a good byte (rx_valid) or a bad stop bit (rx_ferr).
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       rxd_sync,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_t       state_q, state_d;
    logic [CW-1:0]   tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            prev_q, prev_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    // Each phase counts down from its delay and acts on the tick that reaches zero.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        prev_d  = prev_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (ce) begin
            prev_d = rxd_sync;
            unique case (state_q)
                RX_IDLE: begin
                    if (prev_q && !rxd_sync) begin
                        state_d = RX_START;
                        tick_d  = HALF_M1;
                    end
                end
                RX_START: begin
                    if (tick_q != '0) begin
                        tick_d = tick_q - CW'(1);
                    end else if (rxd_sync) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        tick_d  = FULL_M1;
                        bit_d   = 3'd0;
                    end
                end
                RX_DATA: begin
                    if (tick_q != '0) begin
                        tick_d = tick_q - CW'(1);
                    end else begin
                        shift_d = {rxd_sync, shift_q[7:1]};
                        tick_d  = FULL_M1;
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick_q != '0) begin
                        tick_d = tick_q - CW'(1);
                    end else begin
                        state_d = RX_IDLE;
                        valid_d = rxd_sync;
                        ferr_d  = !rxd_sync;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RX_IDLE;
            tick_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            prev_q  <= 1'b1;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_valid = valid_q;
    assign rx_byte  = shift_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_loader.sv
// Boot loader: receives a checksummed image over UART, writes the 12-bit words
// to memory and holds the core until the whole image has been verified.
module uart_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int ADDR_WIDTH   = 12,
    parameter int BASE_ADDR    = 0,
    parameter int MAX_WORDS    = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce,
    input  logic                  rxd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [11:0]           mem_data,
    output logic                  mem_we,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [8:0]            MAX_N = 9'(MAX_WORDS);

    logic rxd_meta_q, rxd_sync_q;
    logic rx_valid, rx_ferr;
    logic [7:0] rx_byte;

    loader_state_t         state_q, state_d;
    logic [7:0]            count_q, count_d;
    logic [7:0]            idx_q, idx_d;
    logic [7:0]            chk_q, chk_d;
    logic [3:0]            nib_q, nib_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [11:0]           data_q, data_d;
    logic                  we_q, we_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .rxd_sync (rxd_sync_q),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_ferr  (rx_ferr)
    );

    // ERROR behaves like IDLE so a fresh sync byte restarts the load.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        nib_d   = nib_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        if (rx_ferr && state_q != ST_DONE) begin
            state_d = ST_ERROR;
        end else if (rx_valid) begin
            unique case (state_q)
                ST_IDLE, ST_ERROR: begin
                    if (rx_byte == LOADER_SYNC_BYTE) begin
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (rx_byte == 8'd0 || {1'b0, rx_byte} > MAX_N) begin
                        state_d = ST_ERROR;
                    end else begin
                        count_d = rx_byte;
                        chk_d   = rx_byte;
                        idx_d   = 8'd0;
                        state_d = ST_WORD_HI;
                    end
                end
                ST_WORD_HI: begin
                    if (rx_byte[7:4] != 4'd0) begin
                        state_d = ST_ERROR;
                    end else begin
                        nib_d   = rx_byte[3:0];
                        chk_d   = chk_q ^ rx_byte;
                        state_d = ST_WORD_LO;
                    end
                end
                ST_WORD_LO: begin
                    we_d    = 1'b1;
                    addr_d  = BASE + ADDR_WIDTH'(idx_q);
                    data_d  = {nib_q, rx_byte};
                    chk_d   = chk_q ^ rx_byte;
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q + 8'd1 == count_q) ? ST_CHECK : ST_WORD_HI;
                end
                ST_CHECK: begin
                    state_d = (rx_byte == chk_q) ? ST_DONE : ST_ERROR;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= 8'd0;
            idx_q   <= 8'd0;
            chk_q   <= 8'd0;
            nib_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= 12'd0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            nib_q   <= nib_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_data  = data_q;
    assign mem_we    = we_q;
    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERROR);
    assign core_hold = (state_q != ST_DONE);

endmodule
